// File: rtl/pcie_rx_vc_buffer.sv
// Receive-side PCIe virtual-channel buffer: an in-order TLP FIFO with a show-ahead head and
// flow-control credit return (cumulative CREDITS_ALLOCATED, one credit per TLP slot).
module pcie_rx_vc_buffer #(
  parameter int DATA_WIDTH    = 224,
  parameter int DEPTH         = 16,
  parameter int UPDATE_THRESH = 4,
  parameter int UPDATE_TIMER  = 255
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [DATA_WIDTH-1:0]        rx_data,
  output logic                         tl_valid,
  output logic [DATA_WIDTH-1:0]        tl_data,
  input  logic                         tl_ready,
  output logic                         fc_update_valid,
  output logic [7:0]                   fc_update_credits,
  input  logic                         fc_update_ack,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic                         overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int TMR_W = (UPDATE_TIMER > 1) ? $clog2(UPDATE_TIMER) : 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_SEND
  } state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  wr_en;
  logic                  pop;

  state_t                state;
  state_t                state_nxt;
  logic [OCC_W-1:0]      pending;
  logic [OCC_W-1:0]      pending_nxt;
  logic [TMR_W-1:0]      timer;
  logic [TMR_W-1:0]      timer_nxt;
  logic [7:0]            credits_nxt;
  logic                  trigger;

  assign full     = (occupancy == OCC_W'(DEPTH));
  assign wr_en    = rx_valid && !full;
  assign tl_valid = (occupancy != '0);
  assign pop      = tl_valid && tl_ready;
  assign tl_data  = tl_valid ? mem[rd_ptr] : '0;

  // Storage array carries no reset; only valid entries are ever presented.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      occupancy    <= '0;
      overflow_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)   rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (wr_en && !pop)      occupancy <= occupancy + 1'b1;
      else if (!wr_en && pop) occupancy <= occupancy - 1'b1;
      // A same-cycle pop does not excuse a write to a full buffer: that slot was never advertised.
      if (rx_valid && full) overflow_err <= 1'b1;
    end
  end

  assign trigger = (pending >= OCC_W'(UPDATE_THRESH)) ||
                   ((pending != '0) && (timer == TMR_W'(UPDATE_TIMER - 1)));

  always_comb begin
    state_nxt   = state;
    credits_nxt = fc_update_credits;
    pending_nxt = pending + OCC_W'(pop);
    timer_nxt   = '0;
    case (state)
      ST_INIT: begin
        state_nxt   = ST_SEND;
        credits_nxt = 8'(DEPTH);
      end
      ST_IDLE: begin
        if (trigger) begin
          credits_nxt = fc_update_credits + 8'(pending);
          pending_nxt = OCC_W'(pop);
          state_nxt   = ST_SEND;
        end else if (pending != '0) begin
          timer_nxt = timer + 1'b1;
        end
      end
      ST_SEND: begin
        if (fc_update_ack) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_INIT;
      pending           <= '0;
      timer             <= '0;
      fc_update_credits <= '0;
      fc_update_valid   <= 1'b0;
    end else begin
      state             <= state_nxt;
      pending           <= pending_nxt;
      timer             <= timer_nxt;
      fc_update_credits <= credits_nxt;
      fc_update_valid   <= (state_nxt == ST_SEND);
    end
  end

endmodule

// File: tb/tb_pcie_rx_vc_buffer.sv
// Bench for pcie_rx_vc_buffer: directed credit/FIFO scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_pcie_rx_vc_buffer;

  localparam int DW     = 224;
  localparam int DEPTH  = 16;
  localparam int THRESH = 4;
  localparam int TIMER  = 255;
  localparam int OCC_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             rx_valid = 1'b0;
  logic [DW-1:0]    rx_data = '0;
  logic             tl_valid;
  logic [DW-1:0]    tl_data;
  logic             tl_ready = 1'b0;
  logic             fc_update_valid;
  logic [7:0]       fc_update_credits;
  logic             fc_update_ack = 1'b0;
  logic [OCC_W-1:0] occupancy;
  logic             overflow_err;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Behavioural model state
  logic [DW-1:0] mq[$];
  bit            m_ovf;
  bit            m_fresh;     // just out of reset, initial advertisement not yet made
  bit            m_sending;
  int            m_credits;
  int            m_pending;
  int            m_idle_cnt;  // consecutive idle cycles with pending>0

  pcie_rx_vc_buffer #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .UPDATE_THRESH(THRESH), .UPDATE_TIMER(TIMER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tl_valid(tl_valid), .tl_data(tl_data), .tl_ready(tl_ready),
    .fc_update_valid(fc_update_valid), .fc_update_credits(fc_update_credits),
    .fc_update_ack(fc_update_ack), .occupancy(occupancy), .overflow_err(overflow_err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d = '0;
    for (int i = 0; i < DW / 32; i++) d = (d << 32) | DW'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_fresh = 1; m_sending = 0;
    m_credits = 0; m_pending = 0; m_idle_cnt = 0;
  endtask

  // One clock of the model: a TLP popped only if one was already visible, a write accepted
  // only if a slot was free before this edge.
  task automatic model_step(input bit v, input logic [DW-1:0] d, input bit r, input bit a);
    bit popped = (mq.size() > 0) && r;
    bit stored = v && (mq.size() < DEPTH);
    if (v && mq.size() == DEPTH) m_ovf = 1;
    if (popped) void'(mq.pop_front());
    if (stored) mq.push_back(d);
    if (m_fresh) begin
      m_fresh = 0; m_sending = 1; m_credits = DEPTH;
      m_pending += popped;
    end else if (m_sending) begin
      if (a) m_sending = 0;
      m_pending += popped;
      m_idle_cnt = 0;
    end else if (m_pending >= THRESH || (m_pending > 0 && m_idle_cnt == TIMER - 1)) begin
      m_credits = (m_credits + m_pending) % 256;
      m_pending = popped;
      m_idle_cnt = 0;
      m_sending = 1;
    end else begin
      m_idle_cnt = (m_pending > 0) ? m_idle_cnt + 1 : 0;
      m_pending += popped;
    end
  endtask

  task automatic tick(input bit v, input logic [DW-1:0] d, input bit r, input bit a);
    rx_valid = v; rx_data = d; tl_ready = r; fc_update_ack = a;
    @(posedge clk);
    model_step(v, d, r, a);
    #1;
    rx_valid = 0; tl_ready = 0; fc_update_ack = 0;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++;
    if ({tl_valid, fc_update_valid, overflow_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {tl_valid, fc_update_valid, overflow_err});
    else pass_cnt++;
    chk_cnt++;
    if (tl_data !== '0) $display("FAIL reset_tl_data: got %0h want 0", tl_data);
    else pass_cnt++;
    chk_cnt++;
    if (occupancy !== '0 || fc_update_credits !== 8'd0) $display("FAIL reset_counts: got occ %0d cred %0d want 0 0", occupancy, fc_update_credits);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_init_advert();
    tick(0, '0, 0, 0);
    chk_cnt++;
    if (fc_update_valid !== 1'b1 || fc_update_credits !== 8'd16) $display("FAIL init_advert: got v%b cred %0d want v1 cred 16", fc_update_valid, fc_update_credits);
    else pass_cnt++;
    tick(0, '0, 0, 0);
    chk_cnt++;
    if (fc_update_valid !== 1'b1 || fc_update_credits !== 8'd16) $display("FAIL init_hold: got v%b cred %0d want v1 cred 16", fc_update_valid, fc_update_credits);
    else pass_cnt++;
    tick(0, '0, 0, 1);
    repeat (5) tick(0, '0, 0, 0);
    chk_cnt++;
    if (fc_update_valid !== 1'b0) $display("FAIL init_ack_idle: got valid %b want 0", fc_update_valid);
    else pass_cnt++;
  endtask

  task automatic test_fill_overflow();
    logic [DW-1:0] first = rand_data();
    tick(1, first, 0, 0);
    chk_cnt++;
    if (tl_valid !== 1'b1 || tl_data !== first) $display("FAIL first_visible: got v%b %0h want v1 %0h", tl_valid, tl_data, first);
    else pass_cnt++;
    for (int i = 1; i < DEPTH; i++) tick(1, rand_data(), 0, 0);
    chk_cnt++;
    if (occupancy !== OCC_W'(16) || overflow_err !== 1'b0) $display("FAIL full_occ: got occ %0d ovf %b want 16 0", occupancy, overflow_err);
    else pass_cnt++;
    tick(1, rand_data(), 0, 0);
    repeat (3) tick(0, '0, 0, 0);
    chk_cnt++;
    if (occupancy !== OCC_W'(16) || overflow_err !== 1'b1) $display("FAIL overflow: got occ %0d ovf %b want 16 1", occupancy, overflow_err);
    else pass_cnt++;
    chk_cnt++;
    if (tl_data !== first || tl_data !== mq[0]) $display("FAIL head_after_ovf: got %0h want %0h", tl_data, first);
    else pass_cnt++;
  endtask

  task automatic test_threshold();
    for (int i = 0; i < THRESH; i++) begin
      chk_cnt++;
      if (tl_data !== mq[0]) $display("FAIL pop_order: got %0h want %0h", tl_data, mq[0]);
      else pass_cnt++;
      tick(0, '0, 1, 0);
    end
    chk_cnt++;
    if (fc_update_valid !== 1'b0) $display("FAIL thresh_early: got valid %b want 0", fc_update_valid);
    else pass_cnt++;
    tick(0, '0, 0, 0);
    chk_cnt++;
    if (fc_update_valid !== 1'b1 || fc_update_credits !== 8'd20) $display("FAIL thresh_update: got v%b cred %0d want v1 cred 20", fc_update_valid, fc_update_credits);
    else pass_cnt++;
    tick(0, '0, 0, 1);
  endtask

  task automatic test_timer();
    int n = 0;
    tick(0, '0, 1, 0);
    while (n < 400 && fc_update_valid !== 1'b1) begin
      tick(0, '0, 0, 0);
      n++;
    end
    chk_cnt++;
    if (n != TIMER) $display("FAIL timer_delay: got %0d cycles want %0d", n, TIMER);
    else pass_cnt++;
    chk_cnt++;
    if (fc_update_credits !== 8'd21 || fc_update_credits !== 8'(m_credits)) $display("FAIL timer_credits: got %0d want 21", fc_update_credits);
    else pass_cnt++;
  endtask

  task automatic test_ack_hold();
    for (int i = 0; i < 6; i++) begin
      tick(0, '0, 1, 0);
      chk_cnt++;
      if (fc_update_valid !== 1'b1 || fc_update_credits !== 8'd21) $display("FAIL hold_stable: got v%b cred %0d want v1 cred 21", fc_update_valid, fc_update_credits);
      else pass_cnt++;
    end
    tick(0, '0, 0, 1);
    chk_cnt++;
    if (fc_update_valid !== 1'b0) $display("FAIL hold_ack: got valid %b want 0", fc_update_valid);
    else pass_cnt++;
    tick(0, '0, 0, 0);
    chk_cnt++;
    if (fc_update_valid !== 1'b1 || fc_update_credits !== 8'd27) $display("FAIL hold_next: got v%b cred %0d want v1 cred 27", fc_update_valid, fc_update_credits);
    else pass_cnt++;
    tick(0, '0, 0, 1);
  endtask

  task automatic test_wrap_simul();
    repeat (3) tick(1, rand_data(), 0, 0);
    chk_cnt++;
    if (occupancy !== OCC_W'(8)) $display("FAIL wrap_setup: got occ %0d want 8", occupancy);
    else pass_cnt++;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1, rand_data(), 1, 1);
      chk_cnt++;
      if (occupancy !== OCC_W'(8) || tl_data !== mq[0]) $display("FAIL wrap_step%0d: got occ %0d %0h want 8 %0h", i, occupancy, tl_data, mq[0]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d = rand_data();
    rst_n = 1'b0;
    #2;
    model_reset();
    chk_cnt++;
    if (occupancy !== '0 || tl_valid !== 1'b0 || overflow_err !== 1'b0 || fc_update_valid !== 1'b0 || fc_update_credits !== 8'd0)
      $display("FAIL midreset: got occ %0d tv %b ovf %b fv %b cred %0d want all 0", occupancy, tl_valid, overflow_err, fc_update_valid, fc_update_credits);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(0, '0, 0, 0);
    chk_cnt++;
    if (fc_update_valid !== 1'b1 || fc_update_credits !== 8'd16) $display("FAIL readvert: got v%b cred %0d want v1 cred 16", fc_update_valid, fc_update_credits);
    else pass_cnt++;
    tick(1, d, 1, 1);
    chk_cnt++;
    if (occupancy !== OCC_W'(1) || tl_valid !== 1'b1 || tl_data !== d) $display("FAIL empty_write_ready: got occ %0d %0h want 1 %0h", occupancy, tl_data, d);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_data;
    for (int i = 0; i < 1500; i++) begin
      tick(($urandom % 4) != 0, rand_data(), ($urandom % 3) != 0, $urandom % 2);
      exp_data = (mq.size() > 0) ? mq[0] : '0;
      chk_cnt++;
      if (occupancy !== OCC_W'(mq.size()) || tl_valid !== (mq.size() > 0) || tl_data !== exp_data)
        $display("FAIL rand_fifo@%0d: got occ %0d tv %b %0h want %0d %0h", i, occupancy, tl_valid, tl_data, mq.size(), exp_data);
      else pass_cnt++;
      chk_cnt++;
      if (fc_update_valid !== m_sending || fc_update_credits !== 8'(m_credits) || overflow_err !== m_ovf)
        $display("FAIL rand_fc@%0d: got v%b cred %0d ovf %b want v%b cred %0d ovf %b", i, fc_update_valid, fc_update_credits, overflow_err, m_sending, m_credits, m_ovf);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_init_advert();
    test_fill_overflow();
    test_threshold();
    test_timer();
    test_ack_hold();
    test_wrap_simul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
